// File: rtl/vs_shared_reg_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit control register among NUM_REQ agents.
// A granted agent may lock the register to keep ownership across read-modify-write sequences.
module vs_shared_reg_arbiter #(
  parameter int               NUM_REQ     = 4,
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int              IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       lock,
  input  logic [2*NUM_REQ-1:0]     op,
  input  logic [WIDTH*NUM_REQ-1:0] wdata,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]         q,
  output logic                     update,
  output logic                     locked,
  output logic [IDX_W-1:0]         owner
);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   ptr_reg;
  logic [IDX_W-1:0]   owner_reg;
  logic [WIDTH-1:0]   q_reg;
  logic               update_reg;

  logic [1:0]         op_arr   [NUM_REQ];
  logic [WIDTH-1:0]   data_arr [NUM_REQ];

  logic [NUM_REQ-1:0] gnt_vec;
  logic [IDX_W-1:0]   gnt_idx;
  logic               found;
  int                 cand;
  logic [IDX_W-1:0]   cand_idx;
  logic               xfer;
  logic [1:0]         sel_op;
  logic [WIDTH-1:0]   sel_data;
  logic [WIDTH-1:0]   q_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign op_arr[gi]   = op[2*gi +: 2];
      assign data_arr[gi] = wdata[WIDTH*gi +: WIDTH];
    end
  endgenerate

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    if (int'(idx) == NUM_REQ - 1)
      return '0;
    else
      return idx + 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] apply_op(input logic [1:0]       code,
                                                input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] d);
    case (code)
      2'b00:   return d;
      2'b01:   return cur | d;
      2'b10:   return cur & ~d;
      default: return cur ^ d;
    endcase
  endfunction

  // Grant is combinational so a requester is served in the cycle it asks;
  // reset_n gates it directly so no grant is visible while reset is held.
  always_comb begin
    gnt_vec  = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    if (!reset_n) begin
      gnt_vec = '0;
    end else if (state_reg == ST_LOCKED) begin
      gnt_idx = owner_reg;
      if (req[owner_reg])
        gnt_vec[owner_reg] = 1'b1;
    end else begin
      for (int off = 0; off < NUM_REQ; off++) begin
        cand = int'(ptr_reg) + off;
        if (cand >= NUM_REQ)
          cand = cand - NUM_REQ;
        cand_idx = IDX_W'(cand);
        if (!found && req[cand_idx]) begin
          found             = 1'b1;
          gnt_idx           = cand_idx;
          gnt_vec[cand_idx] = 1'b1;
        end
      end
    end
  end

  assign xfer     = |gnt_vec;
  assign sel_op   = op_arr[gnt_idx];
  assign sel_data = data_arr[gnt_idx];
  assign q_next   = apply_op(sel_op, q_reg, sel_data);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_UNLOCKED;
      ptr_reg    <= '0;
      owner_reg  <= '0;
      q_reg      <= RESET_VALUE;
      update_reg <= 1'b0;
    end else begin
      update_reg <= xfer;
      if (xfer) begin
        q_reg     <= q_next;
        owner_reg <= gnt_idx;
        case (state_reg)
          ST_UNLOCKED: begin
            // Taking the lock leaves ptr alone so rotation resumes after the owner on release.
            if (lock[gnt_idx])
              state_reg <= ST_LOCKED;
            else
              ptr_reg <= wrap_inc(gnt_idx);
          end
          ST_LOCKED: begin
            if (!lock[gnt_idx]) begin
              state_reg <= ST_UNLOCKED;
              ptr_reg   <= wrap_inc(gnt_idx);
            end
          end
          default: state_reg <= ST_UNLOCKED;
        endcase
      end
    end
  end

  assign gnt    = gnt_vec;
  assign q      = q_reg;
  assign update = update_reg;
  assign locked = (state_reg == ST_LOCKED);
  assign owner  = owner_reg;

`ifndef SYNTHESIS
  a_req_known: assert property (@(posedge clock) disable iff (!reset_n) !$isunknown(req))
    else $error("req carries X/Z");
  a_gnt_onehot0: assert property (@(posedge clock) disable iff (!reset_n) $onehot0(gnt_vec))
    else $error("gnt not one-hot or zero");
  a_gnt_subset: assert property (@(posedge clock) disable iff (!reset_n) (gnt_vec & ~req) == '0)
    else $error("gnt not a subset of req");
  a_lock_owner: assert property (@(posedge clock) disable iff (!reset_n)
      (state_reg != ST_LOCKED) || ((gnt_vec & ~(NUM_REQ'(1) << owner_reg)) == '0))
    else $error("grant to non-owner while locked");
`endif

endmodule
